vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

- Generates the 640x480 VGA frame sequence: horizontal and vertical counters, active-low HSYNC/VSYNC, display enable, and zero-based pixel column/row.
- Emits line-start and frame-start strobes.
- Arbitrates a single sprite-memory update requester so that updates happen only during vertical blanking.
- Sits between the system clock domain and the horizontal/vertical display decoders and the sprite renderer.

## Interface
Parameters:
- H_SYNC, 96, horizontal sync width in pixel ticks
- H_BP, 48, horizontal back porch
- H_ACT, 640, horizontal active pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, vertical active lines
- V_FP, 10, vertical front porch

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  reset; one clock; reset is asynchronous and active-low
- UPD_REQ  in  1  sprite update request, level
- H_Counts  out  10  horizontal count, 0..799
- V_Counts  out  10  vertical count, 0..524
- HSYNC  out  1  active-low horizontal sync
- VSYNC  out  1  active-low vertical sync
- display  out  1  high inside both active windows
- Display_Col  out  10  H_Counts-(H_SYNC+H_BP) when display is high, else 0
- Display_Row  out  10  V_Counts-(V_SYNC+V_BP) when display is high, else 0
- PIX_TICK  out  1  one-clock pulse per pixel advance
- LINE_START  out  1  one-clock pulse when H_Counts wraps to 0
- FRAME_START  out  1  one-clock pulse when H_Counts and V_Counts both wrap to 0
- UPD_GNT  out  1  update grant

## Operation
- All outputs are registered. Reset value of every output is 0, except HSYNC=1 and VSYNC=1.
- PIX_TICK is derived from the pixel-rate enable (see Configuration). Counters advance only on a PIX_TICK cycle.
- Horizontal counter:
  - H_Counts increments to H_TOT-1=799, then wraps to 0.
  - On each wrap, V_Counts increments; it wraps from V_TOT-1=524 to 0.
- Sync decode:
  - HSYNC=0 while H_Counts<H_SYNC.
  - VSYNC=0 while V_Counts<V_SYNC.
- Active window:
  - display=1 when H_Counts is in [144,783] and V_Counts is in [35,514].
  - Col and row are obtained by subtraction from the counters, never by accumulation.
- Vertical blanking (vblank) is V_Counts<35 or V_Counts>=515.
- Arbiter FSM states:
  - IDLE: UPD_REQ=1 → WAIT_VBL.
  - WAIT_VBL: enter GRANT at the first LINE_START that falls inside vblank. If UPD_REQ drops first → IDLE.
  - GRANT: UPD_GNT=1.
    - UPD_REQ=0 → IDLE.
    - If the next line would be V_Counts=35 and H_Counts is about to wrap → RELEASE, with GNT cleared that same cycle.
  - RELEASE: UPD_GNT=0. Hold until UPD_REQ=0, then → IDLE. A request still asserted at the end of vblank is therefore not re-granted until it is dropped and re-raised.
- Widths: all count arithmetic is 10-bit unsigned. Totals are localparams computed from the parameters.

## Timing
- Counter update latency: 1 clock after the PIX_TICK cycle.
- HSYNC, VSYNC, display, Col, Row and strobes are aligned to the same clock edge as the counter values they describe; there is no extra pipeline skew.
- LINE_START and FRAME_START are each high for exactly one CLK.
- UPD_GNT rises 1 clock after the qualifying LINE_START cycle. It falls no later than the edge on which V_Counts becomes 35.
- UPD_REQ rising during GRANT or RELEASE has no effect.
- Reset mid-frame: counters return to 0 asynchronously and the FSM goes to IDLE. The first FRAME_START after reset release is at H=0, V=0 after one full frame.

## Configuration
- VGA_PIX_DIV_EN defined:
  - A 1-bit toggle divides CLK by 2, so PIX_TICK is high every other cycle (50 MHz input, 25 MHz pixel rate).
  - The toggle resets to 0, and the first PIX_TICK occurs on the second clock after reset.
- Not defined: PIX_TICK is tied high and counters advance every CLK.

## Structure
- Shared package vga_pkg holds:
  - the 640x480 timing constants;
  - derived totals 800/525;
  - the arbiter state enum upd_state_t {IDLE, WAIT_VBL, GRANT, RELEASE}.
- One sub-module is natural: vga_upd_arbiter. It contains the FSM; its inputs are LINE_START, a vblank flag, the end-of-vblank flag and UPD_REQ.

## Test plan
- Reset, then free-run without VGA_PIX_DIV_EN → H_Counts period 800 clocks; HSYNC low for 96 clocks; FRAME_START period 420000 clocks.
- With VGA_PIX_DIV_EN → PIX_TICK alternates 0/1; H_Counts period 1600 clocks; VSYNC low for exactly 2 lines.
- Sample at H=144, V=35 → display=1, Col=0, Row=0. At H=783, V=514 → Col=639, Row=479. At H=784 → display=0, Col=0.
- UPD_REQ raised at V=200 → GNT stays 0 until the LINE_START entering V=515, then rises 1 clock later. Drop REQ at V=520 → GNT=0 next clock; FSM in IDLE.
- UPD_REQ held through end of vblank → GNT falls when V becomes 35 and stays 0 through the next vblank until REQ toggles low, then high.
- Assert RESET_N=0 at H=400, V=300 while in WAIT_VBL → all outputs at reset values immediately; GNT stays 0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, derived frame totals, arbiter state encoding
// and the registered video-decode bundle.
package vga_pkg;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_H_ACT  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;
  localparam int unsigned VGA_V_ACT  = 480;
  localparam int unsigned VGA_V_FP   = 10;

  localparam int unsigned VGA_H_TOT = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
  localparam int unsigned VGA_V_TOT = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;

  // Counter width covers the larger of the two totals (10 bits for 800/525).
  localparam int unsigned CNT_W = $clog2((VGA_H_TOT > VGA_V_TOT) ? VGA_H_TOT : VGA_V_TOT);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBL,
    GRANT,
    RELEASE
  } upd_state_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display;
    cnt_t col;
    cnt_t row;
  } vid_dec_t;

  localparam vid_dec_t DEC_RST = '{hsync: 1'b1, vsync: 1'b1, display: 1'b0, col: '0, row: '0};
endpackage

// File: rtl/vga_upd_arbiter.sv
// Sprite-memory update arbiter: grants a single requester only inside vertical
// blanking and withdraws the grant before the first active line.
module vga_upd_arbiter
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line_start,
  input  logic vblank,
  input  logic vblank_end,
  input  logic upd_req,
  output logic upd_gnt
);
  upd_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      upd_gnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      upd_gnt <= (state_nxt == GRANT);
    end
  end

  // A request held across end of vblank parks in RELEASE until it is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (upd_req) state_nxt = WAIT_VBL;
      WAIT_VBL: begin
        if (!upd_req)                 state_nxt = IDLE;
        else if (line_start && vblank) state_nxt = GRANT;
      end
      GRANT: begin
        if (!upd_req)        state_nxt = IDLE;
        else if (vblank_end) state_nxt = RELEASE;
      end
      RELEASE:  if (!upd_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA frame timing: h/v counters, syncs, display window, strobes, vblank-gated
// sprite update grant. Define VGA_PIX_DIV_EN to run pixels at CLK/2.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned H_ACT  = VGA_H_ACT,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP,
  parameter int unsigned V_ACT  = VGA_V_ACT,
  parameter int unsigned V_FP   = VGA_V_FP
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       UPD_REQ,
  output logic [9:0] H_Counts,
  output logic [9:0] V_Counts,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       display,
  output logic [9:0] Display_Col,
  output logic [9:0] Display_Row,
  output logic       PIX_TICK,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       UPD_GNT
);
  localparam cnt_t H_TOT  = cnt_t'(H_SYNC + H_BP + H_ACT + H_FP);
  localparam cnt_t V_TOT  = cnt_t'(V_SYNC + V_BP + V_ACT + V_FP);
  localparam cnt_t H_LAST = H_TOT - cnt_t'(1);
  localparam cnt_t V_LAST = V_TOT - cnt_t'(1);
  localparam cnt_t H_SY   = cnt_t'(H_SYNC);
  localparam cnt_t V_SY   = cnt_t'(V_SYNC);
  localparam cnt_t H_A0   = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_A1   = cnt_t'(H_SYNC + H_BP + H_ACT);
  localparam cnt_t V_A0   = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_A1   = cnt_t'(V_SYNC + V_BP + V_ACT);
  localparam cnt_t V_EOV  = V_A0 - cnt_t'(1);

  function automatic vid_dec_t decode(input cnt_t h, input cnt_t v);
    vid_dec_t d;
    d.hsync   = (h >= H_SY);
    d.vsync   = (v >= V_SY);
    d.display = (h >= H_A0) && (h < H_A1) && (v >= V_A0) && (v < V_A1);
    d.col     = d.display ? (h - H_A0) : '0;
    d.row     = d.display ? (v - V_A0) : '0;
    return d;
  endfunction

  logic     h_wrap, v_wrap, vblank, vblank_end;
  cnt_t     h_nxt, v_nxt;
  vid_dec_t dec_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) PIX_TICK <= 1'b0;
`ifdef VGA_PIX_DIV_EN
    else          PIX_TICK <= ~PIX_TICK;
`else
    else          PIX_TICK <= 1'b1;
`endif
  end

  assign h_wrap = (H_Counts == H_LAST);
  assign v_wrap = (V_Counts == V_LAST);
  assign h_nxt  = h_wrap ? '0 : H_Counts + cnt_t'(1);
  assign v_nxt  = !h_wrap ? V_Counts : (v_wrap ? '0 : V_Counts + cnt_t'(1));

  // Decode the next count values so every output lands on the same edge as the counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      H_Counts    <= '0;
      V_Counts    <= '0;
      dec_q       <= DEC_RST;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (PIX_TICK) begin
      H_Counts    <= h_nxt;
      V_Counts    <= v_nxt;
      dec_q       <= decode(h_nxt, v_nxt);
      LINE_START  <= h_wrap;
      FRAME_START <= h_wrap && v_wrap;
    end else begin
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

  assign HSYNC       = dec_q.hsync;
  assign VSYNC       = dec_q.vsync;
  assign display     = dec_q.display;
  assign Display_Col = dec_q.col;
  assign Display_Row = dec_q.row;

  assign vblank     = (V_Counts < V_A0) || (V_Counts >= V_A1);
  assign vblank_end = PIX_TICK && h_wrap && (V_Counts == V_EOV);

  vga_upd_arbiter u_arb (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .line_start (LINE_START),
    .vblank     (vblank),
    .vblank_end (vblank_end),
    .upd_req    (UPD_REQ),
    .upd_gnt    (UPD_GNT)
  );
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: full 640x480 instance for line timing and window corners,
// reduced-timing instance (20x13 totals) for frame, vblank arbitration and reset.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;
`ifdef VGA_PIX_DIV_EN
  localparam int TPIX     = 2;
  localparam int FIRST_FS = 520;
`else
  localparam int TPIX     = 1;
  localparam int FIRST_FS = 261;
`endif
  localparam int LIM = 40000 * TPIX;

  logic clk;
  logic rst_a, rst_b, req_a, req_b;
  logic [9:0] h_a, v_a, col_a, row_a, h_b, v_b, col_b, row_b;
  logic hs_a, vs_a, de_a, tick_a, ls_a, fs_a, gnt_a;
  logic hs_b, vs_b, de_b, tick_b, ls_b, fs_b, gnt_b;
  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_ctrl dut_a (
    .CLK(clk), .RESET_N(rst_a), .UPD_REQ(req_a), .H_Counts(h_a), .V_Counts(v_a),
    .HSYNC(hs_a), .VSYNC(vs_a), .display(de_a), .Display_Col(col_a), .Display_Row(row_a),
    .PIX_TICK(tick_a), .LINE_START(ls_a), .FRAME_START(fs_a), .UPD_GNT(gnt_a)
  );

  vga_timing_ctrl #(
    .H_SYNC(4), .H_BP(4), .H_ACT(8), .H_FP(4),
    .V_SYNC(2), .V_BP(3), .V_ACT(6), .V_FP(2)
  ) dut_b (
    .CLK(clk), .RESET_N(rst_b), .UPD_REQ(req_b), .H_Counts(h_b), .V_Counts(v_b),
    .HSYNC(hs_b), .VSYNC(vs_b), .display(de_b), .Display_Col(col_b), .Display_Row(row_b),
    .PIX_TICK(tick_b), .LINE_START(ls_b), .FRAME_START(fs_b), .UPD_GNT(gnt_b)
  );

  task automatic wait_hv(input bit on_b, input int h, input int v, input bit need_ls, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < LIM) begin
      if (on_b) hit = (int'(h_b) == h) && (int'(v_b) == v) && (!need_ls || ls_b);
      else      hit = (int'(h_a) == h) && (int'(v_a) == v) && (!need_ls || ls_a);
      if (!hit) begin @(negedge clk); n++; end
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for H=%0d V=%0d", tag, h, v);
    end
  endtask

  task automatic test_reset();
    logic [46:0] exp_rst;
    bit exp_tick;
    int exp_h;
    exp_rst = {20'd0, 2'b11, 1'b0, 20'd0, 4'd0};
    checks++;
    if ({h_a, v_a, hs_a, vs_a, de_a, col_a, row_a, tick_a, ls_a, fs_a, gnt_a} !== exp_rst) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", {h_a, v_a, hs_a, vs_a, de_a, col_a, row_a, tick_a, ls_a, fs_a, gnt_a}, exp_rst);
    end
    checks++;
    if ({h_b, v_b, hs_b, vs_b, de_b, col_b, row_b, tick_b, ls_b, fs_b, gnt_b} !== exp_rst) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", {h_b, v_b, hs_b, vs_b, de_b, col_b, row_b, tick_b, ls_b, fs_b, gnt_b}, exp_rst);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_tick = (TPIX == 1) || (i % 2 == 0);
      exp_h    = (TPIX == 1) ? i : (i + 1) / 2;
      checks++;
      if (tick_a !== exp_tick) begin
        failures++;
        $display("FAIL pix_tick cycle %0d got=%b exp=%b", i, tick_a, exp_tick);
      end
      checks++;
      if (int'(h_a) != exp_h) begin
        failures++;
        $display("FAIL h_start cycle %0d got=%0d exp=%0d", i, h_a, exp_h);
      end
    end
  endtask

  task automatic test_hperiod();
    int cnt, lo, ls;
    wait_hv(1'b0, 0, 1, 1'b1, "hper");
    cnt = 0; lo = 0; ls = 0;
    do begin
      if (!hs_a) lo++;
      if (ls_a) ls++;
      cnt++;
      @(negedge clk);
    end while (!ls_a && cnt < 4000);
    checks++;
    if (cnt != 800 * TPIX) begin failures++; $display("FAIL h_period got=%0d exp=%0d", cnt, 800 * TPIX); end
    checks++;
    if (lo != 96 * TPIX) begin failures++; $display("FAIL hsync_low got=%0d exp=%0d", lo, 96 * TPIX); end
    checks++;
    if (ls != 1) begin failures++; $display("FAIL line_start_width got=%0d exp=1", ls); end
  endtask

  task automatic test_display_full();
    wait_hv(1'b0, 143, 35, 1'b0, "disp143");
    checks++;
    if ({de_a, col_a, row_a} !== {1'b0, 10'd0, 10'd0}) begin failures++; $display("FAIL win_h143 got=%b/%0d/%0d exp=0/0/0", de_a, col_a, row_a); end
    wait_hv(1'b0, 144, 35, 1'b0, "disp144");
    checks++;
    if ({de_a, col_a, row_a} !== {1'b1, 10'd0, 10'd0}) begin failures++; $display("FAIL win_first got=%b/%0d/%0d exp=1/0/0", de_a, col_a, row_a); end
    wait_hv(1'b0, 783, 35, 1'b0, "disp783");
    checks++;
    if ({de_a, col_a, row_a} !== {1'b1, 10'd639, 10'd0}) begin failures++; $display("FAIL win_h783 got=%b/%0d/%0d exp=1/639/0", de_a, col_a, row_a); end
    wait_hv(1'b0, 784, 35, 1'b0, "disp784");
    checks++;
    if ({de_a, col_a, row_a} !== {1'b0, 10'd0, 10'd0}) begin failures++; $display("FAIL win_h784 got=%b/%0d/%0d exp=0/0/0", de_a, col_a, row_a); end
    wait_hv(1'b0, 144, 36, 1'b0, "disp_r1");
    checks++;
    if ({de_a, col_a, row_a} !== {1'b1, 10'd0, 10'd1}) begin failures++; $display("FAIL win_row1 got=%b/%0d/%0d exp=1/0/1", de_a, col_a, row_a); end
  endtask

  task automatic test_display_small();
    wait_hv(1'b1, 7, 5, 1'b0, "sdisp0");
    checks++;
    if ({de_b, col_b, row_b} !== {1'b0, 10'd0, 10'd0}) begin failures++; $display("FAIL swin_h7 got=%b/%0d/%0d exp=0/0/0", de_b, col_b, row_b); end
    wait_hv(1'b1, 8, 5, 1'b0, "sdisp1");
    checks++;
    if ({de_b, col_b, row_b} !== {1'b1, 10'd0, 10'd0}) begin failures++; $display("FAIL swin_first got=%b/%0d/%0d exp=1/0/0", de_b, col_b, row_b); end
    wait_hv(1'b1, 15, 10, 1'b0, "sdisp2");
    checks++;
    if ({de_b, col_b, row_b} !== {1'b1, 10'd7, 10'd5}) begin failures++; $display("FAIL swin_last got=%b/%0d/%0d exp=1/7/5", de_b, col_b, row_b); end
    wait_hv(1'b1, 16, 10, 1'b0, "sdisp3");
    checks++;
    if ({de_b, col_b, row_b} !== {1'b0, 10'd0, 10'd0}) begin failures++; $display("FAIL swin_h16 got=%b/%0d/%0d exp=0/0/0", de_b, col_b, row_b); end
    wait_hv(1'b1, 8, 11, 1'b0, "sdisp4");
    checks++;
    if ({de_b, col_b, row_b} !== {1'b0, 10'd0, 10'd0}) begin failures++; $display("FAIL swin_v11 got=%b/%0d/%0d exp=0/0/0", de_b, col_b, row_b); end
  endtask

  task automatic test_frame();
    int cnt, lo, fs;
    wait_hv(1'b1, 0, 0, 1'b1, "frame");
    checks++;
    if (fs_b !== 1'b1) begin failures++; $display("FAIL frame_start_at_0 got=%b exp=1", fs_b); end
    cnt = 0; lo = 0; fs = 0;
    do begin
      if (!vs_b) lo++;
      if (fs_b) fs++;
      cnt++;
      @(negedge clk);
    end while (!fs_b && cnt < 2000);
    checks++;
    if (cnt != 260 * TPIX) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", cnt, 260 * TPIX); end
    checks++;
    if (lo != 40 * TPIX) begin failures++; $display("FAIL vsync_low got=%0d exp=%0d", lo, 40 * TPIX); end
    checks++;
    if (fs != 1) begin failures++; $display("FAIL frame_start_width got=%0d exp=1", fs); end
  endtask

  task automatic test_upd_grant();
    int n, bad;
    wait_hv(1'b1, 10, 7, 1'b0, "greq");
    req_b = 1'b1;
    n = 0; bad = 0;
    while (!(ls_b && v_b == 10'd11) && n < LIM) begin
      @(negedge clk);
      if (gnt_b) bad++;
      n++;
    end
    checks++;
    if (n >= LIM || bad != 0) begin failures++; $display("FAIL gnt_before_vbl got=%0d early grants exp=0", bad); end
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL gnt_rise got=%b exp=1", gnt_b); end
    wait_hv(1'b1, 5, 12, 1'b0, "gdrop");
    req_b = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b0) begin failures++; $display("FAIL gnt_drop got=%b exp=0", gnt_b); end
    wait_hv(1'b1, 10, 12, 1'b0, "greraise");
    req_b = 1'b1;
    wait_hv(1'b1, 0, 0, 1'b1, "gregrant");
    checks++;
    if (gnt_b !== 1'b0) begin failures++; $display("FAIL gnt_regrant_ls got=%b exp=0", gnt_b); end
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL gnt_regrant got=%b exp=1", gnt_b); end
  endtask

  task automatic test_upd_hold();
    int bad;
    wait_hv(1'b1, 19, 4, 1'b0, "hold_eov");
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL gnt_last_vbl got=%b exp=1", gnt_b); end
    wait_hv(1'b1, 0, 5, 1'b1, "hold_act");
    checks++;
    if (gnt_b !== 1'b0) begin failures++; $display("FAIL gnt_at_v5 got=%b exp=0", gnt_b); end
    bad = 0;
    repeat (260 * TPIX - 1) begin
      @(negedge clk);
      if (gnt_b) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL gnt_held_release got=%0d grant cycles exp=0", bad); end
    wait_hv(1'b1, 3, 5, 1'b0, "hold_toggle");
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    req_b = 1'b1;
    wait_hv(1'b1, 0, 11, 1'b1, "hold_regrant");
    checks++;
    if (gnt_b !== 1'b0) begin failures++; $display("FAIL gnt_toggle_ls got=%b exp=0", gnt_b); end
    @(negedge clk);
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL gnt_toggle got=%b exp=1", gnt_b); end
  endtask

  task automatic test_reset_midframe();
    logic [46:0] exp_rst;
    int n, bad;
    exp_rst = {20'd0, 2'b11, 1'b0, 20'd0, 4'd0};
    req_b = 1'b0;
    wait_hv(1'b1, 10, 7, 1'b0, "rst_pos");
    req_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    checks++;
    if ({h_b, v_b, hs_b, vs_b, de_b, col_b, row_b, tick_b, ls_b, fs_b, gnt_b} !== exp_rst) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {h_b, v_b, hs_b, vs_b, de_b, col_b, row_b, tick_b, ls_b, fs_b, gnt_b}, exp_rst);
    end
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    n = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (gnt_b) bad++;
    end while (!fs_b && n < LIM);
    checks++;
    if (n != FIRST_FS) begin failures++; $display("FAIL first_frame_start got=%0d exp=%0d", n, FIRST_FS); end
    checks++;
    if ({h_b, v_b} !== 20'd0) begin failures++; $display("FAIL first_fs_pos got=H%0d/V%0d exp=H0/V0", h_b, v_b); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL gnt_after_reset got=%0d grant cycles exp=0", bad); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_hperiod();
    test_display_full();
    test_display_small();
    test_frame();
    test_upd_grant();
    test_upd_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
